// File: rtl/cam_stream_pkg.sv
// Shared constants, packet field positions and receiver state type for the
// 4-bit CAM packet stream.
package cam_stream_pkg;

    localparam int          CAM_NIBBLES = 8;
    localparam logic [15:0] HB_ADDR     = 16'hC0FF;
    localparam logic [6:0]  HB_FLAGS    = 7'b1010101;

    localparam int ADDR_MSB    = 31;
    localparam int ADDR_LSB    = 16;
    localparam int DATA_MSB    = 15;
    localparam int DATA_LSB    = 8;
    localparam int RW_N_BIT    = 7;
    localparam int M2SEL_N_BIT = 6;
    localparam int M2B0_BIT    = 5;
    localparam int SW_GS_BIT   = 4;
    localparam int RESET_BIT   = 0;

    typedef enum logic {
        ST_HUNT  = 1'b0,
        ST_SHIFT = 1'b1
    } cam_rx_state_e;

    function automatic logic is_heartbeat(input logic [31:0] w);
        return (w[ADDR_MSB:ADDR_LSB] == HB_ADDR) && (w[RW_N_BIT:1] == HB_FLAGS);
    endfunction

endpackage

// File: rtl/cam_rx_sync.sv
// Brings cam_pclk/cam_sync/cam_data into clk_i with two-flop synchronisers and
// turns each synchronised pclk rise into a one-cycle nibble strobe.
module cam_rx_sync (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       cam_pclk,
    input  logic       cam_sync,
    input  logic [3:0] cam_data,
    output logic       nib_stb,
    output logic [3:0] nib_data,
    output logic       nib_sync
);

    logic       pclk_s1_q, pclk_s2_q, pclk_s3_q;
    logic       pclk_s1_d, pclk_s2_d, pclk_s3_d;
    logic       sync_s1_q, sync_s2_q, sync_s1_d, sync_s2_d;
    logic [3:0] data_s1_q, data_s2_q, data_s1_d, data_s2_d;

    always_comb begin
        pclk_s1_d = cam_pclk;
        pclk_s2_d = pclk_s1_q;
        pclk_s3_d = pclk_s2_q;
        sync_s1_d = cam_sync;
        sync_s2_d = sync_s1_q;
        data_s1_d = cam_data;
        data_s2_d = data_s1_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pclk_s1_q <= 1'b0;
            pclk_s2_q <= 1'b0;
            pclk_s3_q <= 1'b0;
            sync_s1_q <= 1'b0;
            sync_s2_q <= 1'b0;
            data_s1_q <= 4'd0;
            data_s2_q <= 4'd0;
        end else begin
            pclk_s1_q <= pclk_s1_d;
            pclk_s2_q <= pclk_s2_d;
            pclk_s3_q <= pclk_s3_d;
            sync_s1_q <= sync_s1_d;
            sync_s2_q <= sync_s2_d;
            data_s1_q <= data_s1_d;
            data_s2_q <= data_s2_d;
        end
    end

    // Data and sync settle before the pclk rise, so their s2 copies are valid here.
    assign nib_stb  = pclk_s2_q & ~pclk_s3_q;
    assign nib_data = data_s2_q;
    assign nib_sync = sync_s2_q;

endmodule

// File: rtl/cam_deserializer.sv
// Reassembles 32-bit CAM packets from the synchronised nibble stream and holds
// them on a valid/ready port, counting framing errors, overruns and heartbeat gaps.
module cam_deserializer
    import cam_stream_pkg::*;
#(
    parameter logic ENABLE         = 1'b1,
    parameter int   TIMEOUT_CYCLES = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cam_pclk,
    input  logic        cam_sync,
    input  logic [3:0]  cam_data,
    input  logic        pkt_ready,
    output logic        pkt_valid,
    output logic [31:0] pkt_word,
    output logic        pkt_is_reset,
    output logic        pkt_is_heartbeat,
    output logic [15:0] pkt_count,
    output logic [15:0] frame_err_count,
    output logic [15:0] overrun_count,
    output logic [15:0] hb_gap_count,
    output logic        overrun_flag
);

    localparam int                 TIMER_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]         CNT_LAST   = 3'(CAM_NIBBLES - 1);

    logic       raw_stb, stb, nib_sync;
    logic [3:0] nib_data;

    cam_rx_sync u_sync (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .cam_pclk (cam_pclk),
        .cam_sync (cam_sync),
        .cam_data (cam_data),
        .nib_stb  (raw_stb),
        .nib_data (nib_data),
        .nib_sync (nib_sync)
    );

    assign stb = ENABLE & raw_stb;

    cam_rx_state_e      state_q, state_d;
    logic [27:0]        shift_q, shift_d;
    logic [2:0]         cnt_q, cnt_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               timeout, deliver, frame_err;
    logic [31:0]        new_word;

    logic        pkt_valid_q, pkt_valid_d, overrun_flag_q, overrun_flag_d;
    logic [31:0] pkt_word_q, pkt_word_d;
    logic [15:0] pkt_count_q, pkt_count_d, frame_err_count_q, frame_err_count_d;
    logic [15:0] overrun_count_q, overrun_count_d, hb_gap_count_q, hb_gap_count_d;
    logic [7:0]  hb_last_q, hb_last_d;
    logic        hb_seen_q, hb_seen_d;
    logic        accept, drop;

    assign timeout  = (state_q == ST_SHIFT) && !stb && (timer_q == TIMER_LAST);
    assign new_word = {shift_q, nib_data};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= ST_HUNT;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_HUNT:  if (stb && nib_sync) state_d = ST_SHIFT;
            ST_SHIFT: begin
                if (stb && !nib_sync && cnt_q == CNT_LAST) state_d = ST_HUNT;
                else if (timeout)                          state_d = ST_HUNT;
            end
            default:  state_d = ST_HUNT;
        endcase
    end

    always_comb begin
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        timer_d   = '0;
        deliver   = 1'b0;
        frame_err = 1'b0;
        case (state_q)
            ST_HUNT: begin
                if (stb && nib_sync) begin
                    shift_d = {24'd0, nib_data};
                    cnt_d   = 3'd1;
                end
            end
            ST_SHIFT: begin
                if (stb) begin
                    if (nib_sync) begin
                        frame_err = 1'b1;
                        shift_d   = {24'd0, nib_data};
                        cnt_d     = 3'd1;
                    end else if (cnt_q == CNT_LAST) begin
                        deliver = 1'b1;
                        cnt_d   = 3'd0;
                    end else begin
                        shift_d = {shift_q[23:0], nib_data};
                        cnt_d   = cnt_q + 3'd1;
                    end
                end else if (timeout) begin
                    frame_err = 1'b1;
                    cnt_d     = 3'd0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // A delivery into a full, non-draining output is dropped without touching heartbeat state.
    always_comb begin
        accept            = deliver & (~pkt_valid_q | pkt_ready);
        drop              = deliver & ~accept;
        pkt_valid_d       = accept ? 1'b1 : (pkt_ready ? 1'b0 : pkt_valid_q);
        pkt_word_d        = accept ? new_word : pkt_word_q;
        pkt_count_d       = pkt_count_q + {15'd0, accept};
        overrun_count_d   = overrun_count_q + {15'd0, drop};
        overrun_flag_d    = overrun_flag_q | drop;
        frame_err_count_d = frame_err_count_q + {15'd0, frame_err};
        hb_gap_count_d    = hb_gap_count_q;
        hb_last_d         = hb_last_q;
        hb_seen_d         = hb_seen_q;
        if (accept) begin
            if (new_word[RESET_BIT]) hb_seen_d = 1'b0;
            if (is_heartbeat(new_word)) begin
                if (hb_seen_q && new_word[DATA_MSB:DATA_LSB] != hb_last_q + 8'd1)
                    hb_gap_count_d = hb_gap_count_q + 16'd1;
                hb_last_d = new_word[DATA_MSB:DATA_LSB];
                hb_seen_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shift_q           <= '0;
            cnt_q             <= '0;
            timer_q           <= '0;
            pkt_valid_q       <= 1'b0;
            pkt_word_q        <= '0;
            pkt_count_q       <= '0;
            frame_err_count_q <= '0;
            overrun_count_q   <= '0;
            hb_gap_count_q    <= '0;
            overrun_flag_q    <= 1'b0;
            hb_last_q         <= '0;
            hb_seen_q         <= 1'b0;
        end else begin
            shift_q           <= shift_d;
            cnt_q             <= cnt_d;
            timer_q           <= timer_d;
            pkt_valid_q       <= pkt_valid_d;
            pkt_word_q        <= pkt_word_d;
            pkt_count_q       <= pkt_count_d;
            frame_err_count_q <= frame_err_count_d;
            overrun_count_q   <= overrun_count_d;
            hb_gap_count_q    <= hb_gap_count_d;
            overrun_flag_q    <= overrun_flag_d;
            hb_last_q         <= hb_last_d;
            hb_seen_q         <= hb_seen_d;
        end
    end

    assign pkt_valid        = pkt_valid_q;
    assign pkt_word         = pkt_word_q;
    assign pkt_is_reset     = pkt_word_q[RESET_BIT];
    assign pkt_is_heartbeat = is_heartbeat(pkt_word_q);
    assign pkt_count        = pkt_count_q;
    assign frame_err_count  = frame_err_count_q;
    assign overrun_count    = overrun_count_q;
    assign hb_gap_count     = hb_gap_count_q;
    assign overrun_flag     = overrun_flag_q;

endmodule

// File: doc/cam_deserializer.md
# cam_deserializer

- Receive side of the 4-bit CAM packet stream driven by `cam_serializer`.
- Oversamples `cam_pclk`, `cam_sync` and `cam_data` in its own clock domain, reassembles 32-bit bus-capture packets and presents them on a valid/ready port with decoded fields.
- Tracks framing errors, output overruns and heartbeat sequence gaps.
- Sits in the loopback/test harness and on the ESP32-side bridge; its downstream is a packet FIFO or the bench scoreboard.

## Interface
Parameters:
- `ENABLE`, 1'b1: when 0, no nibble is ever accepted; outputs hold their reset values.
- `TIMEOUT_CYCLES`, 64: number of `clk_i` cycles without a `cam_pclk` rise, mid-packet, that aborts the packet.

Ports:
- `clk_i`  in  1  receiver clock; at least 4× the `cam_pclk` rate.
- `rst_i`  in  1  asynchronous, active-high reset.
- `cam_pclk`  in  1  stream clock, asynchronous to `clk_i`.
- `cam_sync`  in  1  high with the first nibble of a packet.
- `cam_data`  in  4  nibble, MSB nibble first.
- `pkt_ready`  in  1  downstream accepts the packet.
- `pkt_valid`  out  1  packet held on the outputs.
- `pkt_word`  out  32  raw packet {addr[31:16], data[15:8], flags[7:0]}.
- `pkt_is_reset`  out  1  `pkt_word[0]`.
- `pkt_is_heartbeat`  out  1  addr==16'hC0FF and flags[7:1]==7'b1010101.
- `pkt_count`  out  16  packets delivered; wraps.
- `frame_err_count`  out  16  framing errors; wraps.
- `overrun_count`  out  16  packets dropped because the output was full; wraps.
- `hb_gap_count`  out  16  heartbeat sequence gaps; wraps.
- `overrun_flag`  out  1  sticky; cleared only by reset.

## Operation
- Synchroniser: each of `cam_pclk`, `cam_sync` and `cam_data` passes through 2 flops to produce `*_s2`. A third flop on pclk gives `pclk_s3`.
- `nib_stb = pclk_s2 & ~pclk_s3`. On `nib_stb`, the sampled nibble is `data_s2` and the sampled sync is `sync_s2`.
- Transmitter contract: data and sync change only while `cam_pclk` is low, and are stable at least one `clk_i` period before the `cam_pclk` rise.
- FSM states are HUNT and SHIFT; reset state is HUNT.
  - HUNT, `nib_stb` & sync: `shift` ← nibble, `cnt` ← 1, go to SHIFT.
  - HUNT, `nib_stb` & !sync: discard the nibble; no count.
  - SHIFT, `nib_stb` & !sync & `cnt` < 7: `shift` ← {shift[23:0], nibble}, `cnt`++.
  - SHIFT, `nib_stb` & !sync & `cnt` == 7: packet complete; deliver {shift[27:0], nibble}; go to HUNT.
  - SHIFT, `nib_stb` & sync: resync. `frame_err_count`++, restart with `cnt` ← 1 and stay in SHIFT.
  - SHIFT, idle timer reaches `TIMEOUT_CYCLES`: `frame_err_count`++, go to HUNT. The idle timer is cleared on every `nib_stb` and on entry to SHIFT.
- Output register, on delivery:
  - If `pkt_valid` is 0, or `pkt_ready` is 1 in the same cycle: load the register and keep `pkt_valid` at 1; `pkt_count`++.
  - Otherwise: drop the new packet, `overrun_count`++, set `overrun_flag`.
- `pkt_valid` clears when `pkt_ready` is high and there is no simultaneous delivery.
- Heartbeat check, evaluated at delivery time:
  - Reset packet: clears `hb_seen`.
  - Heartbeat packet with `hb_seen`=1 and data ≠ `hb_last`+1 (mod 256): `hb_gap_count`++.
  - Every heartbeat packet: `hb_last` ← data, `hb_seen` ← 1.
  - Dropped packets do not update the heartbeat state.

## Timing
- Latency: if edge k is the first `clk_i` edge to sample `cam_pclk` high on the 8th nibble, `nib_stb` is high during cycle k+1 and `pkt_valid` rises at edge k+2. All counters update at that same edge k+2.
- Minimum `cam_pclk` high and low time is 2 `clk_i` periods, so at most one `nib_stb` occurs per pclk cycle.
- Reset values:
  - All outputs 0; FSM in HUNT; `cnt`, `shift`, idle timer, `hb_last` and `hb_seen` all 0.
  - Synchroniser flops reset to 0, so a `cam_pclk` that is high at reset release yields one `nib_stb`.
- Reset asserted mid-packet: the partial packet is lost and no error is counted.
- `pkt_word` and the decoded fields are stable while `pkt_valid` is high and `pkt_ready` is low.

## Structure
- Package `cam_stream_pkg`:
  - constants `CAM_NIBBLES`=8, `HB_ADDR`=16'hC0FF, `HB_FLAGS`=7'b1010101;
  - field index localparams (ADDR 31:16, DATA 15:8, RW_N 7, M2SEL_N 6, M2B0 5, SW_GS 4, RESET 0);
  - FSM state enum `cam_rx_state_e`.
- Sub-module `cam_rx_sync`: 2-flop synchronisers plus pclk edge detect; outputs `nib_stb`, `nib_data[3:0]`, `nib_sync`.

## Test plan
- Single packet: 8 nibbles of 32'hC03C_5A80, sync on the first nibble, pclk at clk/4 → `pkt_valid` at edge k+2 with `pkt_word`=32'hC03C_5A80, `pkt_count`=1, `pkt_is_heartbeat`=0.
- Resync: 5 nibbles, then a new sync followed by a full 32'h0000_0001 → `frame_err_count`=1, a single packet delivered with `pkt_is_reset`=1.
- Timeout: 3 nibbles, then 64 idle cycles, then a full packet → `frame_err_count`=1, only the second packet delivered.
- Overrun: `pkt_ready`=0, send 2 packets → first packet held, `overrun_count`=1, `overrun_flag`=1. Raise `pkt_ready` → `pkt_valid` drops the next cycle.
- Heartbeats C0FF_03AA, C0FF_04AA, C0FF_06AA → `hb_gap_count`=1. Then reset packet, then C0FF_10AA → no further increment.
- Assert `rst_i` asynchronously mid-packet → all outputs 0 immediately. After release, a fresh packet is received correctly.
